fetch_stage: RTL and testbench

- Instruction-fetch stage of the basic five-stage pipeline; sits directly upstream of the word-addressed instruction ROM and feeds the decode stage.
- Holds the PC, drives the ROM address combinationally, and registers the returned word, together with its PC and a valid bit, into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages, and halts at end of program.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : fetch_stage
// Description : Instruction-fetch stage with PC, IF/ID register, stall, flush,
//               redirect and end-of-program halt. Optional perf counters are
//               enabled by defining FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter int unsigned IMEM_DEPTH = 82,
    parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [31:0] c_imem_depth = 32'(IMEM_DEPTH);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc_d;
    logic [31:0] if_instr_q;
    logic [31:0] if_instr_d;
    logic        if_valid_q;
    logic        if_valid_d;

    logic        w_oor;
    logic        w_bubble;
    logic        w_load_valid;

    assign w_oor        = (pc_q >= c_imem_depth);
    assign w_bubble     = redirect_i | flush_i;
    assign w_load_valid = ~w_bubble & ~stall_i & ~w_oor;

    // PC next state: redirect beats stall, stall beats halt
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (stall_i || w_oor) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_comb begin
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        if (w_bubble) begin
            if_pc_d    = 32'h0;
            if_instr_d = NOP_WORD;
            if_valid_d = 1'b0;
        end else if (stall_i) begin
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
            if_valid_d = if_valid_q;
        end else if (w_oor) begin
            if_pc_d    = pc_q;
            if_instr_d = NOP_WORD;
            if_valid_d = 1'b0;
        end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_data_i;
            if_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_WORD;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = if_pc_q;
    assign if_id_instr_o = if_instr_q;
    assign if_id_valid_o = if_valid_q;
    assign halted_o      = w_oor;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Both counters saturate rather than wrap
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (w_load_valid && (fetch_cnt_q != 32'hFFFFFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_i && !redirect_i && (stall_cnt_q != 32'hFFFFFFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic w_unused;
    assign w_unused    = w_load_valid;
    assign fetch_cnt_o = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_stage
// Description : Directed, table-driven bench for fetch_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic        halted_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_fcnt = 0;
    logic [31:0] exp_scnt = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o),
        .halted_o      (halted_o),
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a << 7) + 32'h0000008e;
    endfunction

    always_comb imem_data_i = rom(imem_addr_o);

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic f, input logic r, input logic [31:0] rp,
                       input logic [31:0] a, input logic [31:0] p, input logic [31:0] ins,
                       input logic v, input logic h);
        vec_t t;
        t.stall = s; t.flush = f; t.redir = r; t.rpc = rp;
        t.e_addr = a; t.e_pc = p; t.e_instr = ins; t.e_valid = v; t.e_halt = h;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] p,
                           input logic [31:0] ins, input logic v, input logic h);
        chk({tag, " addr"},  imem_addr_o, a);
        chk({tag, " ifpc"},  if_id_pc_o, p);
        chk({tag, " instr"}, if_id_instr_o, ins);
        chk({tag, " valid"}, {31'b0, if_id_valid_o}, {31'b0, v});
        chk({tag, " halt"},  {31'b0, halted_o}, {31'b0, h});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " fcnt"}, fetch_cnt_o, exp_fcnt);
        chk({tag, " scnt"}, stall_cnt_o, exp_scnt);
`else
        chk({tag, " fcnt"}, fetch_cnt_o, 32'h0);
        chk({tag, " scnt"}, stall_cnt_o, 32'h0);
`endif
    endtask

    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
        stall_i = s; flush_i = f; redirect_i = r; redirect_pc_i = rp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // free run from reset
        add(0,0,0,0,  1,  0, rom(0),  1, 0);
        add(0,0,0,0,  2,  1, rom(1),  1, 0);
        add(0,0,0,0,  3,  2, rom(2),  1, 0);
        add(0,0,0,0,  4,  3, rom(3),  1, 0);
        add(0,0,0,0,  5,  4, rom(4),  1, 0);
        // three-cycle stall at pc 5
        add(1,0,0,0,  5,  4, rom(4),  1, 0);
        add(1,0,0,0,  5,  4, rom(4),  1, 0);
        add(1,0,0,0,  5,  4, rom(4),  1, 0);
        add(0,0,0,0,  6,  5, rom(5),  1, 0);
        add(0,0,0,0,  7,  6, rom(6),  1, 0);
        add(0,0,0,0,  8,  7, rom(7),  1, 0);
        add(0,0,0,0,  9,  8, rom(8),  1, 0);
        add(0,0,0,0, 10,  9, rom(9),  1, 0);
        // flush at pc 10
        add(0,1,0,0, 11,  0, 32'h0,   0, 0);
        add(0,0,0,0, 12, 11, rom(11), 1, 0);
        // stall + redirect to 16
        add(1,0,1,16,16,  0, 32'h0,   0, 0);
        add(0,0,0,0, 17, 16, rom(16), 1, 0);
        // stall + flush: PC holds, bubble
        add(1,1,0,0, 17,  0, 32'h0,   0, 0);
        add(0,0,0,0, 18, 17, rom(17), 1, 0);
        // redirect out of range, then halt behaviour
        add(0,0,1,100,100,0, 32'h0,   0, 1);
        add(0,0,0,0,100,100, 32'h0,   0, 1);
        add(1,0,0,0,100,100, 32'h0,   0, 1);
        add(0,0,1,81, 81, 0, 32'h0,   0, 0);
        add(0,0,0,0, 82, 81, rom(81), 1, 1);
        add(0,0,0,0, 82, 82, 32'h0,   0, 1);
        add(0,0,1,0,  0,  0, 32'h0,   0, 0);
        add(0,0,0,0,  1,  0, rom(0),  1, 0);

        #3;
        chk_all("reset_a", 0, 0, 0, 0, 0);
        #5;
        chk_all("reset_b", 0, 0, 0, 0, 0);
        #4;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].rpc);
            step();
            if (vecs[i].e_valid && !vecs[i].stall && !vecs[i].flush && !vecs[i].redir)
                exp_fcnt++;
            if (vecs[i].stall && !vecs[i].redir)
                exp_scnt++;
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_halt);
        end

        // run on to pc 37
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 36; k++) begin
            step();
            exp_fcnt++;
            chk_all($sformatf("run%0d", k), k + 1, k, rom(k), 1, 0);
        end

        // stall, then assert reset mid-cycle
        drive(1, 0, 0, 0);
        step();
        exp_scnt++;
        chk_all("stall37", 37, 36, rom(36), 1, 0);
        #2;
        rst = 1'b1;
        #1;
        exp_fcnt = 0;
        exp_scnt = 0;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);
        step();
        exp_fcnt++;
        chk_all("post_rst", 1, 0, rom(0), 1, 0);
        step();
        exp_fcnt++;
        chk_all("post_rst2", 2, 1, rom(1), 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
